wb_debug_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares one debug-register slave port between a management master (m0) and a secondary/test master (m1).
- Round-robin arbitration with one cycle of latency.
- Grant is held for the full bus cycle, so multi-beat locked accesses are supported.
- A per-access watchdog terminates accesses the slave never acknowledges (e.g. unmapped addresses) with an error pulse, so a master cannot hang the bus.

---
 rtl/wb_debug_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_debug_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_debug_arbiter.sv
// Two-master Wishbone arbiter for the debug-register slave port.
// Round-robin grant, held for the whole bus cycle, with a per-access ack watchdog.
module wb_debug_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [31:0]      m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [31:0]      m0_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_sel_i,
    input  logic [31:0]      m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [31:0]      m1_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    input  logic             s_ack_i,
    input  logic [31:0]      s_dat_i,
    output logic [1:0]       gnt_o,
    output logic [CNT_W-1:0] timeout_count_o
);

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    state_t           state;
    logic             ptr;
    logic [CNT_W-1:0] wdog;

    logic        req0, req1;
    logic        o_cyc, o_stb, o_we;
    logic [3:0]  o_sel;
    logic [31:0] o_adr, o_dat;
    logic        in_own, timeout, ack, err;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Owner select keys off the registered grant only, so the
    // non-owner's inputs never reach an output.
    always_comb begin
        o_cyc = 1'b0;
        o_stb = 1'b0;
        o_we  = 1'b0;
        o_sel = '0;
        o_adr = '0;
        o_dat = '0;
        if (gnt_o[0]) begin
            o_cyc = m0_cyc_i;
            o_stb = m0_stb_i;
            o_we  = m0_we_i;
            o_sel = m0_sel_i;
            o_adr = m0_adr_i;
            o_dat = m0_dat_i;
        end else if (gnt_o[1]) begin
            o_cyc = m1_cyc_i;
            o_stb = m1_stb_i;
            o_we  = m1_we_i;
            o_sel = m1_sel_i;
            o_adr = m1_adr_i;
            o_dat = m1_dat_i;
        end
    end

    assign in_own  = (state == OWN);
    assign timeout = in_own & o_cyc & o_stb & ~s_ack_i & (wdog == TMAX);
    assign ack     = in_own & s_ack_i;
    assign err     = timeout;

    assign s_cyc_o = in_own & o_cyc & ~timeout;
    assign s_stb_o = in_own & o_stb & ~timeout;
    assign s_we_o  = in_own & o_we;
    assign s_sel_o = in_own ? o_sel : 4'h0;
    assign s_adr_o = in_own ? o_adr : 32'h0;
    assign s_dat_o = in_own ? o_dat : 32'h0;

    assign m0_ack_o = ack & gnt_o[0];
    assign m1_ack_o = ack & gnt_o[1];
    assign m0_err_o = err & gnt_o[0];
    assign m1_err_o = err & gnt_o[1];
    assign m0_dat_o = (in_own & gnt_o[0]) ? s_dat_i : 32'h0;
    assign m1_dat_o = (in_own & gnt_o[1]) ? s_dat_i : 32'h0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state           <= IDLE;
            gnt_o           <= 2'b00;
            ptr             <= 1'b0;
            wdog            <= '0;
            timeout_count_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wdog <= '0;
                    if (req0 && (!req1 || !ptr)) begin
                        gnt_o <= 2'b01;
                        state <= OWN;
                    end else if (req1) begin
                        gnt_o <= 2'b10;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (!o_cyc) begin
                        state <= IDLE;
                        gnt_o <= 2'b00;
                        ptr   <= gnt_o[0];
                        wdog  <= '0;
                    end else if (timeout) begin
                        state <= ABORT;
                        wdog  <= '0;
                        if (timeout_count_o != '1)
                            timeout_count_o <= timeout_count_o + CNT_W'(1);
                    end else if (o_stb && !s_ack_i) begin
                        wdog <= wdog + CNT_W'(1);
                    end else begin
                        wdog <= '0;
                    end
                end
                ABORT: begin
                    wdog <= '0;
                    if (!o_cyc) begin
                        state <= IDLE;
                        gnt_o <= 2'b00;
                        ptr   <= gnt_o[0];
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= 2'b00;
                    wdog  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_debug_arbiter.sv
// Directed-vector bench for wb_debug_arbiter.
// Expected values are hand-computed against the block's behaviour.
module tb_wb_debug_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_wdat;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_wdat;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [1:0]  gnt;
    logic [15:0] tcount;

    int checks = 0;
    int errors = 0;
    int early_err;

    wb_debug_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
        .wb_clk_i(clk),
        .wb_rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc),
        .m0_stb_i(m0_stb),
        .m0_we_i(m0_we),
        .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr),
        .m0_dat_i(m0_wdat),
        .m0_ack_o(m0_ack),
        .m0_err_o(m0_err),
        .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc),
        .m1_stb_i(m1_stb),
        .m1_we_i(m1_we),
        .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr),
        .m1_dat_i(m1_wdat),
        .m1_ack_o(m1_ack),
        .m1_err_o(m1_err),
        .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc),
        .s_stb_o(s_stb),
        .s_we_o(s_we),
        .s_sel_o(s_sel),
        .s_adr_o(s_adr),
        .s_dat_o(s_wdat),
        .s_ack_i(s_ack),
        .s_dat_i(s_rdat),
        .gnt_o(gnt),
        .timeout_count_o(tcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0;
        m0_adr = 0; m0_wdat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0;
        m1_adr = 0; m1_wdat = 0;
        s_ack  = 0; s_rdat = 0;
        #12;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_scyc", s_cyc, 1'b0);
        chk("rst_tcount", tcount, 16'h0);
        tick();
        rst_n = 1'b1;

        // single m0 write
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
        m0_adr = 32'h8; m0_wdat = 32'hDEADBEEF;
        #1;
        chk("w_gnt_pre", gnt, 2'b00);
        chk("w_scyc_pre", s_cyc, 1'b0);
        tick();
        chk("w_gnt", gnt, 2'b01);
        chk("w_scyc", s_cyc, 1'b1);
        chk("w_sstb", s_stb, 1'b1);
        chk("w_swe", s_we, 1'b1);
        chk("w_ssel", s_sel, 4'hF);
        chk("w_sadr", s_adr, 32'h8);
        chk("w_sdat", s_wdat, 32'hDEADBEEF);
        chk("w_ack_lo", m0_ack, 1'b0);
        s_ack = 1;
        #1;
        chk("w_ack", m0_ack, 1'b1);
        chk("w_m1ack", m1_ack, 1'b0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        #1;
        chk("w_gnt_hold", gnt, 2'b01);
        tick();
        chk("w_gnt_rel", gnt, 2'b00);

        // back to reset priority, then simultaneous requests
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h20;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h10;
        tick();
        chk("rr1_gnt", gnt, 2'b01);
        chk("rr1_sadr", s_adr, 32'h20);
        s_ack = 1; s_rdat = 32'h5A5A0000;
        #1;
        chk("rr1_ack0", m0_ack, 1'b1);
        chk("rr1_dat0", m0_rdat, 32'h5A5A0000);
        chk("rr1_ack1", m1_ack, 1'b0);
        chk("rr1_dat1", m1_rdat, 32'h0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        chk("rr1_idle", gnt, 2'b00);
        tick();
        chk("rr2_gnt", gnt, 2'b10);
        chk("rr2_sadr", s_adr, 32'h10);
        m1_cyc = 0; m1_stb = 0;
        tick();
        chk("rr2_idle", gnt, 2'b00);
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("rr3_gnt", gnt, 2'b01);

        // m0 releases; m1 takes a locked three-beat read while m0 waits
        m0_cyc = 0; m0_stb = 0;
        tick();
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("lk_gnt", gnt, 2'b10);
        m1_we = 0; m1_adr = 32'hC;
        s_ack = 1; s_rdat = 32'h11110001;
        #1;
        chk("lk_b1_ack", m1_ack, 1'b1);
        chk("lk_b1_dat", m1_rdat, 32'h11110001);
        chk("lk_b1_m0ack", m0_ack, 1'b0);
        chk("lk_b1_sadr", s_adr, 32'hC);
        tick();
        m1_stb = 0; s_ack = 0;
        tick();
        chk("lk_gap1", gnt, 2'b10);
        m1_stb = 1; s_ack = 1; s_rdat = 32'h11110002;
        #1;
        chk("lk_b2_dat", m1_rdat, 32'h11110002);
        chk("lk_b2_m0ack", m0_ack, 1'b0);
        tick();
        m1_stb = 0; s_ack = 0;
        tick();
        chk("lk_gap2", gnt, 2'b10);
        m1_stb = 1; s_ack = 1; s_rdat = 32'h11110003;
        #1;
        chk("lk_b3_dat", m1_rdat, 32'h11110003);
        chk("lk_b3_m0ack", m0_ack, 1'b0);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        #1;
        chk("lk_hold", gnt, 2'b10);
        tick();
        chk("lk_idle", gnt, 2'b00);
        tick();
        chk("lk_m0gnt", gnt, 2'b01);

        // m0 read of an unmapped address: first stb cycle is now
        m0_we = 0; m0_adr = 32'h4;
        early_err = 0;
        for (int k = 1; k < 64; k++) begin
            if (m0_err !== 1'b0 || s_cyc !== 1'b1) early_err++;
            tick();
        end
        chk("to_early", early_err, 0);
        chk("to_err", m0_err, 1'b1);
        chk("to_ack", m0_ack, 1'b0);
        chk("to_scyc", s_cyc, 1'b0);
        chk("to_sstb", s_stb, 1'b0);
        tick();
        chk("to_err_1cyc", m0_err, 1'b0);
        chk("to_abort_scyc", s_cyc, 1'b0);
        chk("to_abort_gnt", gnt, 2'b01);
        chk("to_count", tcount, 16'h1);
        tick();
        chk("to_abort_hold", gnt, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("to_idle", gnt, 2'b00);

        // ack lands in exactly the timeout cycle
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("ta_gnt", gnt, 2'b01);
        for (int k = 1; k < 64; k++) tick();
        s_ack = 1;
        #1;
        chk("ta_ack", m0_ack, 1'b1);
        chk("ta_err", m0_err, 1'b0);
        chk("ta_scyc", s_cyc, 1'b1);
        tick();
        chk("ta_count", tcount, 16'h1);
        chk("ta_gnt_kept", gnt, 2'b01);
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        chk("ta_idle", gnt, 2'b00);

        // asynchronous reset in the middle of an m1 write
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h30;
        m1_wdat = 32'hCAFE0001;
        tick();
        chk("ar_gnt", gnt, 2'b10);
        s_ack = 1;
        #1;
        chk("ar_ack_pre", m1_ack, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ar_scyc", s_cyc, 1'b0);
        chk("ar_ack", m1_ack, 1'b0);
        chk("ar_gnt0", gnt, 2'b00);
        chk("ar_tcount", tcount, 16'h0);
        s_ack = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        rst_n = 1'b1;
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("ar_first_gnt", gnt, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        m1_cyc = 0; m1_stb = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
